det_nxn_seq: RTL and testbench

Sequential, parametrised determinant engine for square matrices of signed elements. It generalises the team's fixed-size combinational determinant to N = 2..4 and element widths W = 4..16. It uses a single time-shared multiplier and Leibniz expansion, with permutations generated by an iterative Heap's algorithm. It sits in the matrix coprocessor datapath behind the operand register file and uses a start/busy/done handshake. It also exposes the exact full-width result alongside the W-bit result and its overflow flag.

---
 rtl/det_nxn_seq.sv | 185 ++++++++++++++++++
 tb/tb_det_nxn_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/det_nxn_seq.sv
// Sequential NxN determinant engine: Leibniz expansion over Heap-ordered permutations,
// one shared multiplier, exact accumulator, start/busy/done handshake.
module det_nxn_seq #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int ACC_W = N*W+5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [N*N*W-1:0]        m,
  output logic                    busy,
  output logic                    done,
  output logic signed [W-1:0]     det,
  output logic signed [ACC_W-1:0] det_full,
  output logic                    ovf
);

  localparam int PW    = N*W;
  localparam int NFACT = (N == 2) ? 2 : (N == 3) ? 6 : 24;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_ACC, S_FIN} state_t;

  state_t                  state_q, state_d;
  logic signed [W-1:0]     mat_q [N*N];
  logic signed [W-1:0]     mat_d [N*N];
  logic [1:0]              p_q [N];
  logic [1:0]              p_d [N];
  logic [1:0]              c_q [N];
  logic [1:0]              c_d [N];
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [PW-1:0]    prod_q, prod_d;
  logic                    sign_q, sign_d;
  logic [4:0]              term_q, term_d;
  logic [1:0]              k_q, k_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic signed [W-1:0]     det_q, det_d;
  logic signed [ACC_W-1:0] det_full_q, det_full_d;
  logic                    ovf_q, ovf_d;

  // True when the value is representable as a W-bit signed number.
  function automatic logic fits_w(input logic signed [ACC_W-1:0] a);
    return a == {{(ACC_W-W){a[W-1]}}, a[W-1:0]};
  endfunction

  logic signed [W-1:0]     elem;
  logic signed [PW-1:0]    elem_ext;
  logic signed [ACC_W-1:0] prod_ext;
  int                      kk, hi, sw;
  logic                    found;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    prod_d     = prod_q;
    sign_d     = sign_q;
    term_d     = term_q;
    k_d        = k_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    det_d      = det_q;
    det_full_d = det_full_q;
    ovf_d      = ovf_q;
    for (int i = 0; i < N*N; i++) mat_d[i] = mat_q[i];
    for (int i = 0; i < N; i++) begin
      p_d[i] = p_q[i];
      c_d[i] = c_q[i];
    end

    kk       = int'(k_q);
    elem     = mat_q[kk*N + int'(p_q[kk])];
    elem_ext = {{(PW-W){elem[W-1]}}, elem};
    prod_ext = {{(ACC_W-PW){prod_q[PW-1]}}, prod_q};

    // Heap's step: the lowest level whose counter has not wrapped yet.
    found = 1'b0;
    hi    = 1;
    for (int t = 1; t < N; t++) begin
      if (!found && int'(c_q[t]) < t) begin
        found = 1'b1;
        hi    = t;
      end
    end
    sw = (hi % 2 == 0) ? 0 : int'(c_q[hi]);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          for (int i = 0; i < N*N; i++) mat_d[i] = m[i*W +: W];
          for (int i = 0; i < N; i++) begin
            p_d[i] = 2'(i);
            c_d[i] = 2'd0;
          end
          acc_d   = '0;
          prod_d  = PW'(1);
          sign_d  = 1'b0;
          term_d  = 5'd0;
          k_d     = 2'd0;
          busy_d  = 1'b1;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        prod_d = prod_q * elem_ext;
        if (k_q == 2'(N-1)) begin
          k_d     = 2'd0;
          state_d = S_ACC;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      S_ACC: begin
        acc_d  = sign_q ? acc_q - prod_ext : acc_q + prod_ext;
        term_d = term_q + 5'd1;
        if (term_q == 5'(NFACT-1)) begin
          busy_d  = 1'b0;
          state_d = S_FIN;
        end else begin
          p_d[sw] = p_q[hi];
          p_d[hi] = p_q[sw];
          c_d[hi] = c_q[hi] + 2'd1;
          for (int j = 0; j < N; j++) if (j < hi) c_d[j] = 2'd0;
          sign_d  = ~sign_q;
          prod_d  = PW'(1);
          k_d     = 2'd0;
          state_d = S_MUL;
        end
      end
      S_FIN: begin
        det_full_d = acc_q;
        ovf_d      = ~fits_w(acc_q);
        det_d      = fits_w(acc_q) ? acc_q[W-1:0] : '0;
        done_d     = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      prod_q     <= '0;
      sign_q     <= 1'b0;
      term_q     <= 5'd0;
      k_q        <= 2'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      det_q      <= '0;
      det_full_q <= '0;
      ovf_q      <= 1'b0;
      for (int i = 0; i < N*N; i++) mat_q[i] <= '0;
      for (int i = 0; i < N; i++) begin
        p_q[i] <= 2'd0;
        c_q[i] <= 2'd0;
      end
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      prod_q     <= prod_d;
      sign_q     <= sign_d;
      term_q     <= term_d;
      k_q        <= k_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      det_q      <= det_d;
      det_full_q <= det_full_d;
      ovf_q      <= ovf_d;
      for (int i = 0; i < N*N; i++) mat_q[i] <= mat_d[i];
      for (int i = 0; i < N; i++) begin
        p_q[i] <= p_d[i];
        c_q[i] <= c_d[i];
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign det      = det_q;
  assign det_full = det_full_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_det_nxn_seq.sv
// Directed bench for det_nxn_seq: three instances (N=4, N=3, N=2, all W=8).
module tb_det_nxn_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start4, start3, start2;
  logic [127:0] m4;
  logic [71:0]  m3;
  logic [31:0]  m2;

  logic               busy4, done4, ovf4;
  logic signed [7:0]  det4;
  logic signed [36:0] full4;
  logic               busy3, done3, ovf3;
  logic signed [7:0]  det3;
  logic signed [28:0] full3;
  logic               busy2, done2, ovf2;
  logic signed [7:0]  det2;
  logic signed [20:0] full2;

  int vecs = 0;
  int errs = 0;

  det_nxn_seq #(.N(4), .W(8)) u4 (.clk(clk), .rst(rst), .start(start4), .m(m4),
    .busy(busy4), .done(done4), .det(det4), .det_full(full4), .ovf(ovf4));
  det_nxn_seq #(.N(3), .W(8)) u3 (.clk(clk), .rst(rst), .start(start3), .m(m3),
    .busy(busy3), .done(done3), .det(det3), .det_full(full3), .ovf(ovf3));
  det_nxn_seq #(.N(2), .W(8)) u2 (.clk(clk), .rst(rst), .start(start2), .m(m2),
    .busy(busy2), .done(done2), .det(det2), .det_full(full2), .ovf(ovf2));

  function automatic logic done_of(input int n);
    return (n == 4) ? done4 : (n == 3) ? done3 : done2;
  endfunction

  function automatic logic busy_of(input int n);
    return (n == 4) ? busy4 : (n == 3) ? busy3 : busy2;
  endfunction

  task automatic set4(input int r, input int c, input int v);
    m4[(r*4+c)*8 +: 8] = 8'(v);
  endtask
  task automatic set3(input int r, input int c, input int v);
    m3[(r*3+c)*8 +: 8] = 8'(v);
  endtask
  task automatic set2(input int r, input int c, input int v);
    m2[(r*2+c)*8 +: 8] = 8'(v);
  endtask

  task automatic load_m3(input logic swap_rows);
    int a [9];
    a = '{2, -1, 0, 1, 3, 2, 0, 1, 4};
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        set3(swap_rows ? (r == 0 ? 1 : r == 1 ? 0 : r) : r, c, a[r*3+c]);
  endtask

  // Pulse start for one edge; returns just after the accepting edge.
  task automatic go(input int n);
    if (n == 4) start4 = 1'b1; else if (n == 3) start3 = 1'b1; else start2 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0; start3 = 1'b0; start2 = 1'b0;
  endtask

  // Bounded wait for done; lat = edges after the accepting edge, bcnt = busy cycles.
  task automatic wait_done(input int n, input int limit, output int lat, output int bcnt);
    lat  = 0;
    bcnt = busy_of(n) ? 1 : 0;
    while (lat < limit) begin
      @(posedge clk); #1;
      lat++;
      if (done_of(n)) break;
      if (busy_of(n)) bcnt++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vecs++; if (busy4 !== 1'b0) begin errs++; $display("FAIL rst_busy: got %b want 0", busy4); end
    vecs++; if (done4 !== 1'b0) begin errs++; $display("FAIL rst_done: got %b want 0", done4); end
    vecs++; if (det4 !== 8'sd0) begin errs++; $display("FAIL rst_det: got %0d want 0", det4); end
    vecs++; if (full4 !== 37'sd0) begin errs++; $display("FAIL rst_full: got %0d want 0", full4); end
    vecs++; if (ovf4 !== 1'b0) begin errs++; $display("FAIL rst_ovf: got %b want 0", ovf4); end
    vecs++; if (det3 !== 8'sd0 || det2 !== 8'sd0) begin errs++; $display("FAIL rst_det32: got %0d/%0d want 0/0", det3, det2); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_identity4;
    int lat, bc;
    m4 = '0;
    for (int i = 0; i < 4; i++) set4(i, i, 1);
    go(4);
    wait_done(4, 200, lat, bc);
    vecs++; if (lat !== 121) begin errs++; $display("FAIL id4_latency: got %0d want 121", lat); end
    vecs++; if (bc !== 120) begin errs++; $display("FAIL id4_busy_cycles: got %0d want 120", bc); end
    vecs++; if (busy4 !== 1'b0) begin errs++; $display("FAIL id4_busy_at_done: got %b want 0", busy4); end
    vecs++; if (det4 !== 8'sd1) begin errs++; $display("FAIL id4_det: got %0d want 1", det4); end
    vecs++; if (full4 !== 37'sd1) begin errs++; $display("FAIL id4_full: got %0d want 1", full4); end
    vecs++; if (ovf4 !== 1'b0) begin errs++; $display("FAIL id4_ovf: got %b want 0", ovf4); end
    @(posedge clk); #1;
    vecs++; if (done4 !== 1'b0) begin errs++; $display("FAIL id4_done_width: got %b want 0", done4); end
    vecs++; if (det4 !== 8'sd1) begin errs++; $display("FAIL id4_det_hold: got %0d want 1", det4); end
  endtask

  task automatic test_n3;
    int lat, bc;
    load_m3(1'b0);
    go(3);
    wait_done(3, 100, lat, bc);
    vecs++; if (lat !== 25) begin errs++; $display("FAIL n3_latency: got %0d want 25", lat); end
    vecs++; if (bc !== 24) begin errs++; $display("FAIL n3_busy_cycles: got %0d want 24", bc); end
    vecs++; if (det3 !== 8'sd24) begin errs++; $display("FAIL n3_det: got %0d want 24", det3); end
    vecs++; if (ovf3 !== 1'b0) begin errs++; $display("FAIL n3_ovf: got %b want 0", ovf3); end
    load_m3(1'b1);
    go(3);
    wait_done(3, 100, lat, bc);
    vecs++; if (det3 !== -8'sd24) begin errs++; $display("FAIL n3_swap_det: got %0d want -24", det3); end
    vecs++; if (full3 !== -29'sd24) begin errs++; $display("FAIL n3_swap_full: got %0d want -24", full3); end
  endtask

  task automatic test_n2_bounds;
    int lat, bc;
    m2 = '0; set2(0, 0, 8); set2(1, 1, -16);
    go(2);
    wait_done(2, 50, lat, bc);
    vecs++; if (lat !== 7) begin errs++; $display("FAIL n2_latency: got %0d want 7", lat); end
    vecs++; if (det2 !== -8'sd128) begin errs++; $display("FAIL n2_min_det: got %0d want -128", det2); end
    vecs++; if (ovf2 !== 1'b0) begin errs++; $display("FAIL n2_min_ovf: got %b want 0", ovf2); end
    m2 = '0; set2(0, 0, -128); set2(1, 1, -1);
    go(2);
    wait_done(2, 50, lat, bc);
    vecs++; if (full2 !== 21'sd128) begin errs++; $display("FAIL n2_ovf_full: got %0d want 128", full2); end
    vecs++; if (det2 !== 8'sd0) begin errs++; $display("FAIL n2_ovf_det: got %0d want 0", det2); end
    vecs++; if (ovf2 !== 1'b1) begin errs++; $display("FAIL n2_ovf_flag: got %b want 1", ovf2); end
  endtask

  task automatic test_diag4_ovf;
    int lat, bc;
    m4 = '0;
    for (int i = 0; i < 4; i++) set4(i, i, 10);
    go(4);
    wait_done(4, 200, lat, bc);
    vecs++; if (full4 !== 37'sd10000) begin errs++; $display("FAIL diag4_full: got %0d want 10000", full4); end
    vecs++; if (det4 !== 8'sd0) begin errs++; $display("FAIL diag4_det: got %0d want 0", det4); end
    vecs++; if (ovf4 !== 1'b1) begin errs++; $display("FAIL diag4_ovf: got %b want 1", ovf4); end
  endtask

  task automatic test_start_held;
    int dones;
    m4 = '0;
    for (int i = 0; i < 4; i++) set4(i, i, 1);
    set4(0, 0, 2);
    start4 = 1'b1;
    @(posedge clk); #1;
    dones = 0;
    for (int t = 0; t < 121; t++) begin
      @(posedge clk); #1;
      if (done4) begin
        dones++;
        start4 = 1'b0;
      end
    end
    start4 = 1'b0;
    vecs++; if (dones !== 1) begin errs++; $display("FAIL held_done_count: got %0d want 1", dones); end
    vecs++; if (det4 !== 8'sd2) begin errs++; $display("FAIL held_det: got %0d want 2", det4); end
    repeat (3) @(posedge clk);
    #1;
    vecs++; if (busy4 !== 1'b0) begin errs++; $display("FAIL held_no_requeue: got busy %b want 0", busy4); end
  endtask

  task automatic test_m_change;
    int lat, bc;
    load_m3(1'b0);
    go(3);
    repeat (5) @(posedge clk);
    #1;
    m3 = '0;
    for (int i = 0; i < 3; i++) set3(i, i, 1);
    wait_done(3, 100, lat, bc);
    vecs++; if (det3 !== 8'sd24) begin errs++; $display("FAIL mchg_det: got %0d want 24", det3); end
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    m2 = '0; set2(0, 0, 8); set2(1, 1, -16);
    go(2);
    wait_done(2, 50, lat, bc);
    vecs++; if (det2 !== -8'sd128) begin errs++; $display("FAIL b2b_first_det: got %0d want -128", det2); end
    // Now in the done cycle: issue the next start immediately.
    set2(0, 0, 3); set2(0, 1, 1); set2(1, 0, 2); set2(1, 1, 5);
    go(2);
    wait_done(2, 50, lat, bc);
    vecs++; if (lat !== 7) begin errs++; $display("FAIL b2b_latency: got %0d want 7", lat); end
    vecs++; if (det2 !== 8'sd13) begin errs++; $display("FAIL b2b_det: got %0d want 13", det2); end
  endtask

  task automatic test_mid_reset;
    int lat, bc, dones;
    m4 = '0;
    for (int i = 0; i < 4; i++) set4(i, i, 1);
    go(4);
    repeat (49) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    vecs++; if (busy4 !== 1'b0) begin errs++; $display("FAIL mrst_busy: got %b want 0", busy4); end
    vecs++; if (full4 !== 37'sd0) begin errs++; $display("FAIL mrst_full: got %0d want 0", full4); end
    vecs++; if (ovf4 !== 1'b0) begin errs++; $display("FAIL mrst_ovf: got %b want 0", ovf4); end
    vecs++; if (det4 !== 8'sd0 || done4 !== 1'b0) begin errs++; $display("FAIL mrst_det_done: got %0d/%b want 0/0", det4, done4); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    dones = 0;
    for (int t = 0; t < 130; t++) begin
      @(posedge clk); #1;
      if (done4) dones++;
    end
    vecs++; if (dones !== 0) begin errs++; $display("FAIL mrst_no_done: got %0d dones want 0", dones); end
    m4 = '0;
    for (int i = 0; i < 4; i++) set4(i, i, 1);
    set4(3, 3, -3);
    go(4);
    wait_done(4, 200, lat, bc);
    vecs++; if (lat !== 121) begin errs++; $display("FAIL mrst_restart_latency: got %0d want 121", lat); end
    vecs++; if (det4 !== -8'sd3) begin errs++; $display("FAIL mrst_restart_det: got %0d want -3", det4); end
  endtask

  initial begin
    start4 = 1'b0; start3 = 1'b0; start2 = 1'b0;
    m4 = '0; m3 = '0; m2 = '0;
    rst = 1'b0;
    test_reset;
    test_identity4;
    test_n3;
    test_n2_bounds;
    test_diag4_ovf;
    test_start_held;
    test_m_change;
    test_back_to_back;
    test_mid_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
